// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// funct codes, FSM state encoding and the default operand width.
package muldiv_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // True for every funct this block owns (HI/LO moves and mul/div).
    function automatic logic in_group(input logic [5:0] fn);
        return (fn[5:2] == 4'b0100) || (fn[5:2] == 4'b0110);
    endfunction

    function automatic logic is_muldiv(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-division step on the {acc_hi, acc_lo} register pair.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    input  logic             div_mode,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        hi_next = '0;
        lo_next = '0;
        if (div_mode) begin
            // diff[WIDTH] is the borrow: set means the trial subtract failed.
            if (!diff[WIDTH]) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the MIPS HI/LO pair;
// also executes MFHI/MTHI/MFLO/MTLO and stalls EX while an op is in flight.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [5:0]       i_funct,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic [WIDTH-1:0] i_rt_data,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] acc_hi, acc_lo, operand;
    logic             mode_div, neg_q, neg_r, div0, done;

    logic             signed_op;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

    assign signed_op = (i_funct == FN_MULT) || (i_funct == FN_DIV);
    assign rs_mag    = (signed_op && i_rs_data[WIDTH-1]) ? -i_rs_data : i_rs_data;
    assign rt_mag    = (signed_op && i_rt_data[WIDTH-1]) ? -i_rt_data : i_rt_data;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .operand  (operand),
        .div_mode (state == ST_DIV),
        .hi_next  (iter_hi),
        .lo_next  (iter_lo)
    );

    // Divide-by-zero keeps the all-ones quotient unsigned; the remainder
    // path naturally restores the original rs.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = (neg_q && !div0) ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi : acc_hi;
        fix_hi   = mode_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = mode_div ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            mode_div <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (i_flush) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_valid && is_muldiv(i_funct)) begin
                            mode_div <= i_funct[1];
                            neg_q    <= signed_op && (i_rs_data[WIDTH-1] ^ i_rt_data[WIDTH-1]);
                            neg_r    <= signed_op && i_rs_data[WIDTH-1];
                            div0     <= i_funct[1] && (i_rt_data == '0);
                            acc_hi   <= '0;
                            acc_lo   <= i_funct[1] ? rs_mag : rt_mag;
                            operand  <= i_funct[1] ? rt_mag : rs_mag;
                            cnt      <= '0;
                            state    <= i_funct[1] ? ST_DIV : ST_MUL;
                        end else if (i_valid && i_funct == FN_MTHI) begin
                            hi <= i_rs_data;
                        end else if (i_valid && i_funct == FN_MTLO) begin
                            lo <= i_rs_data;
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        acc_hi <= iter_hi;
                        acc_lo <= iter_lo;
                        if (cnt == CW'(WIDTH - 1)) begin
                            cnt   <= '0;
                            state <= ST_FIX;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_FIX: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_result = '0;
        if (i_valid && i_funct == FN_MFHI) o_result = hi;
        else if (i_valid && i_funct == FN_MFLO) o_result = lo;
    end

    assign o_stall = i_valid && in_group(i_funct) && (state != ST_IDLE);
    assign o_busy  = (state != ST_IDLE);
    assign o_done  = done;
    assign o_hi    = hi;
    assign o_lo    = lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, signed/unsigned results,
// divide-by-zero, hazard stalls, HI/LO moves, flush and async reset.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result, hi, lo;

    int vectors = 0;
    int miscompares = 0;
    int cycles;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid),
        .i_funct   (funct),
        .i_rs_data (rs),
        .i_rt_data (rt),
        .i_flush   (flush),
        .o_stall   (stall),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result),
        .o_hi      (hi),
        .o_lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
    endtask

    // Issue a mul/div from IDLE and wait for the done cycle.
    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        valid = 1'b1; funct = fn; rs = a; rt = b;
        tick();
        valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        #2 rst_n = 1'b1;
        tick();
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);

        // MULTU max*max: 33 busy cycles, done in the following cycle
        run_op(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, cycles);
        check("multu_busy_cycles", cycles, 33);
        check("multu_done", done, 1'b1);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        tick();
        check("done_pulse_width", done, 1'b0);

        run_op(6'd24, 32'hFFFFFFF9, 32'd3, cycles);
        check("mult_neg_hi", hi, 32'hFFFFFFFF);
        check("mult_neg_lo", lo, 32'hFFFFFFEB);

        run_op(6'd26, 32'hFFFFFFF9, 32'd2, cycles);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);

        run_op(6'd27, 32'd100, 32'd0, cycles);
        check("divu_zero_cycles", cycles, 33);
        check("divu_zero_lo", lo, 32'hFFFFFFFF);
        check("divu_zero_hi", hi, 32'd100);

        run_op(6'd26, 32'h80000000, 32'hFFFFFFFF, cycles);
        check("div_minint_lo", lo, 32'h80000000);
        check("div_minint_hi", hi, 32'h0);

        run_op(6'd26, 32'hFFFFFFFB, 32'd0, cycles);
        check("div_zero_neg_lo", lo, 32'hFFFFFFFF);
        check("div_zero_neg_hi", hi, 32'hFFFFFFFB);

        run_op(6'd27, 32'd100, 32'd7, cycles);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(6'd25, 32'h12345678, 32'h10, cycles);
        check("multu_small_hi", hi, 32'h1);
        check("multu_small_lo", lo, 32'h23456780);

        // MULT then MFLO: held until the done cycle, then reads the product
        valid = 1'b1; funct = 6'd24; rs = 32'd6; rt = 32'd7;
        tick();
        funct = 6'd18;
        #1;
        check("mflo_stall_busy", stall, 1'b1);
        cycles = 0;
        while (stall && cycles < 100) begin
            cycles++;
            tick();
        end
        check("mflo_stall_cycles", cycles, 33);
        check("mflo_done_cycle", done, 1'b1);
        check("mflo_result", result, 32'd42);
        tick();
        valid = 1'b0;

        valid = 1'b1; funct = 6'd17; rs = 32'h1234;
        #1;
        check("mthi_no_stall", stall, 1'b0);
        tick();
        check("mthi_hi", hi, 32'h1234);
        funct = 6'd16;
        #1;
        check("mfhi_result", result, 32'h1234);
        funct = 6'd18;
        #1;
        check("mflo_idle_result", result, 32'd42);
        funct = 6'd32;
        #1;
        check("non_g_result", result, 32'h0);
        valid = 1'b0;

        // DIVU flushed at iteration 10
        valid = 1'b1; funct = 6'd27; rs = 32'd1000; rt = 32'd3;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_hi", hi, 32'h1234);
        check("flush_lo", lo, 32'd42);
        check("flush_no_done", done, 1'b0);
        valid = 1'b1; funct = 6'd25; rs = 32'd3; rt = 32'd5;
        #1;
        check("post_flush_stall", stall, 1'b0);
        tick();
        valid = 1'b0;
        check("post_flush_accept", busy, 1'b1);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            tick();
        end
        check("post_flush_lo", lo, 32'd15);
        check("post_flush_hi", hi, 32'd0);

        // Flush landing on the FIX cycle must block the write and done
        valid = 1'b1; funct = 6'd25; rs = 32'd9; rt = 32'd9;
        tick();
        valid = 1'b0;
        repeat (32) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fix_lo", lo, 32'd15);
        check("flush_fix_done", done, 1'b0);
        check("flush_fix_busy", busy, 1'b0);

        // Flush suppresses MTLO
        valid = 1'b1; funct = 6'd19; rs = 32'hDEAD; flush = 1'b1;
        tick();
        valid = 1'b0; flush = 1'b0;
        check("flush_mtlo", lo, 32'd15);

        // Async reset mid-DIV
        valid = 1'b1; funct = 6'd26; rs = 32'd100; rt = 32'd7;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Non-group funct never stalls; group funct stalls while busy
        valid = 1'b1; funct = 6'd25; rs = 32'd11; rt = 32'd13;
        tick();
        funct = 6'd32;
        #1;
        check("non_g_no_stall", stall, 1'b0);
        funct = 6'd18;
        #1;
        check("g_stall", stall, 1'b1);
        valid = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            tick();
        end
        check("final_lo", lo, 32'd143);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
